// File: rtl/regfile_param_if.sv
// Bus bundle between the decode/writeback stages and regfile_param.
// The master drives addresses and write data; the slave returns read data and status.
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              write;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] rs;
  logic [DATA_W-1:0] rt;
  logic              init_busy;
  logic              write_drop;

  modport master (
    output rs_addr, rt_addr, rd_addr, write, data_in,
    input  rs, rt, init_busy, write_drop
  );

  modport slave (
    input  rs_addr, rt_addr, rd_addr, write, data_in,
    output rs, rt, init_busy, write_drop
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised 2R/1W register file with post-reset clear sequencer and dropped-write flag.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int DEPTH    = 64,
  parameter int ZERO_REG = 1
) (
  input  logic            clock,
  input  logic            reset,
  regfile_param_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic              r_init_busy;
  logic              r_write_drop;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_wr_ok;
  logic [DATA_W-1:0] w_rs;
  logic [DATA_W-1:0] w_rt;

  // An address is storable when it is implemented and not the hard-wired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    logic in_range;
    logic is_zero;
    in_range = (32'(a) < 32'(DEPTH));
    is_zero  = (ZERO_REG != 0) && (a == '0);
    return in_range && !is_zero;
  endfunction

  function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
    return a[IDX_W-1:0];
  endfunction

  // Write qualification: only in RUN and only to storable addresses.
  always_comb begin
    w_wr_ok = bus.write && (r_state == ST_RUN) && addr_ok(bus.rd_addr);
  end

  // Clear/run sequencer, storage update and registered status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_CLEAR;
      r_clr_ptr    <= '0;
      r_init_busy  <= 1'b1;
      r_write_drop <= 1'b0;
    end else begin
      r_write_drop <= bus.write && !w_wr_ok;
      case (r_state)
        ST_CLEAR: begin
          r_mem[idx(r_clr_ptr)] <= '0;
          if (r_clr_ptr == ADDR_W'(DEPTH - 1)) begin
            r_state     <= ST_RUN;
            r_init_busy <= 1'b0;
          end else begin
            r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
          end
        end
        ST_RUN: begin
          if (w_wr_ok) begin
            r_mem[idx(bus.rd_addr)] <= bus.data_in;
          end else begin
            r_init_busy <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_CLEAR;
          r_clr_ptr   <= '0;
          r_init_busy <= 1'b1;
        end
      endcase
    end
  end

  // Read port A: zero while clearing or for non-storable addresses.
  always_comb begin
    w_rs = '0;
    if (r_state != ST_RUN) begin
      w_rs = '0;
    end else if (!addr_ok(bus.rs_addr)) begin
      w_rs = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (w_wr_ok && (bus.rd_addr == bus.rs_addr)) begin
      w_rs = bus.data_in;
`endif
    end else begin
      w_rs = r_mem[idx(bus.rs_addr)];
    end
  end

  // Read port B: same rules as port A.
  always_comb begin
    w_rt = '0;
    if (r_state != ST_RUN) begin
      w_rt = '0;
    end else if (!addr_ok(bus.rt_addr)) begin
      w_rt = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (w_wr_ok && (bus.rd_addr == bus.rt_addr)) begin
      w_rt = bus.data_in;
`endif
    end else begin
      w_rt = r_mem[idx(bus.rt_addr)];
    end
  end

  assign bus.rs         = w_rs;
  assign bus.rt         = w_rt;
  assign bus.init_busy  = r_init_busy;
  assign bus.write_drop = r_write_drop;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: a DEPTH=64/ZERO_REG=1 instance and a DEPTH=40/ZERO_REG=0 instance.
// Honours REGFILE_BYPASS_EN for the same-cycle forwarding expectations.
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clock;
  logic reset;
  int   n_chk;
  int   n_err;

  regfile_param_if #(.DATA_W(32), .ADDR_W(6)) bus_a ();
  regfile_param_if #(.DATA_W(32), .ADDR_W(6)) bus_b ();

  regfile_param #(.DATA_W(32), .ADDR_W(6), .DEPTH(64), .ZERO_REG(1)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  regfile_param #(.DATA_W(32), .ADDR_W(6), .DEPTH(40), .ZERO_REG(0)) u_dut40 (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    bus_a.rs_addr = 6'd5;  bus_a.rt_addr = 6'd0;  bus_a.rd_addr = 6'd0;
    bus_a.write   = 1'b0;  bus_a.data_in = 32'h0;
    bus_b.rs_addr = 6'd0;  bus_b.rt_addr = 6'd0;  bus_b.rd_addr = 6'd0;
    bus_b.write   = 1'b0;  bus_b.data_in = 32'h0;

    // Reset for two cycles
    tick();
    tick();
    #1;
    chk1("rst_busy", bus_a.init_busy, 1'b1);
    chk1("rst_drop", bus_a.write_drop, 1'b0);
    chk32("rst_rs", bus_a.rs, 32'h0);
    chk32("rst_rt", bus_a.rt, 32'h0);
    reset = 1'b0;

    // Clear sequence: 64 edges for u_dut, 40 for u_dut40; write to r5 on edge 10 is dropped
    for (int k = 1; k <= 64; k++) begin
      if (k == 10) begin
        bus_a.write = 1'b1; bus_a.rd_addr = 6'd5; bus_a.data_in = 32'hDEADBEEF;
      end
      tick();
      bus_a.write = 1'b0;
      #1;
      if (k == 10) begin
        chk1("clr_drop_pulse", bus_a.write_drop, 1'b1);
        chk32("clr_r5_zero", bus_a.rs, 32'h0);
      end
      if (k == 11) chk1("clr_drop_clear", bus_a.write_drop, 1'b0);
      if (k == 39) chk1("clr40_busy_39", bus_b.init_busy, 1'b1);
      if (k == 40) chk1("clr40_busy_40", bus_b.init_busy, 1'b0);
      if (k == 63) chk1("clr_busy_63", bus_a.init_busy, 1'b1);
      if (k == 64) chk1("clr_busy_64", bus_a.init_busy, 1'b0);
    end

    // Every address reads zero after the clear
    for (int a = 0; a < 64; a++) begin
      bus_a.rs_addr = 6'(a);
      bus_a.rt_addr = 6'(63 - a);
      #1;
      chk32($sformatf("zero_rs_%0d", a), bus_a.rs, 32'h0);
      chk32($sformatf("zero_rt_%0d", 63 - a), bus_a.rt, 32'h0);
    end
    bus_a.rs_addr = 6'd5;
    #1;
    chk32("r5_after_clear", bus_a.rs, 32'h0);

    // r3 = 19 then r63 = all ones
    bus_a.write = 1'b1; bus_a.rd_addr = 6'd3; bus_a.data_in = 32'd19;
    bus_a.rs_addr = 6'd0; bus_a.rt_addr = 6'd0;
    tick();
    bus_a.rd_addr = 6'd63; bus_a.data_in = 32'hFFFFFFFF;
    tick();
    bus_a.write = 1'b0;
    bus_a.rs_addr = 6'd3; bus_a.rt_addr = 6'd63;
    #1;
    chk32("r3_read", bus_a.rs, 32'd19);
    chk32("r63_read", bus_a.rt, 32'hFFFFFFFF);
    chk1("r63_no_drop", bus_a.write_drop, 1'b0);

    // Write r0 = 7: dropped with ZERO_REG=1, stored with ZERO_REG=0
    bus_a.write = 1'b1; bus_a.rd_addr = 6'd0; bus_a.data_in = 32'd7;
    bus_b.write = 1'b1; bus_b.rd_addr = 6'd0; bus_b.data_in = 32'd7;
    tick();
    bus_a.write = 1'b0; bus_b.write = 1'b0;
    bus_a.rs_addr = 6'd0; bus_b.rs_addr = 6'd0;
    #1;
    chk32("zr1_r0_read", bus_a.rs, 32'h0);
    chk1("zr1_r0_drop", bus_a.write_drop, 1'b1);
    chk32("zr0_r0_read", bus_b.rs, 32'd7);
    chk1("zr0_r0_no_drop", bus_b.write_drop, 1'b0);

    // DEPTH=40: r45 out of range, r39 storable
    bus_b.write = 1'b1; bus_b.rd_addr = 6'd45; bus_b.data_in = 32'h1234;
    tick();
    bus_b.rd_addr = 6'd39; bus_b.data_in = 32'h0000BEEF;
    bus_b.rs_addr = 6'd45;
    #1;
    chk1("d40_r45_drop", bus_b.write_drop, 1'b1);
    chk32("d40_r45_read", bus_b.rs, 32'h0);
    tick();
    bus_b.write = 1'b0;
    bus_b.rs_addr = 6'd39; bus_b.rt_addr = 6'd45;
    #1;
    chk1("d40_r39_no_drop", bus_b.write_drop, 1'b0);
    chk32("d40_r39_read", bus_b.rs, 32'h0000BEEF);
    chk32("d40_r45_rt", bus_b.rt, 32'h0);

    // Same-cycle write/read of r8 on both ports; forwarding never hits r0
    bus_a.write = 1'b1; bus_a.rd_addr = 6'd8; bus_a.data_in = 32'hA5A5A5A5;
    bus_a.rs_addr = 6'd8; bus_a.rt_addr = 6'd8;
    #1;
    chk32("byp_rs_same", bus_a.rs, BYP ? 32'hA5A5A5A5 : 32'h0);
    chk32("byp_rt_same", bus_a.rt, BYP ? 32'hA5A5A5A5 : 32'h0);
    tick();
    bus_a.rd_addr = 6'd0; bus_a.data_in = 32'h11111111;
    bus_a.rt_addr = 6'd0;
    #1;
    chk32("byp_rs_next", bus_a.rs, 32'hA5A5A5A5);
    chk32("byp_r0_never", bus_a.rt, 32'h0);
    tick();
    bus_a.write = 1'b0;

    // r9 = 55, then reset in RUN and again mid-clear at clr_ptr=20
    bus_a.write = 1'b1; bus_a.rd_addr = 6'd9; bus_a.data_in = 32'd55;
    tick();
    bus_a.write = 1'b0; bus_a.rs_addr = 6'd9; bus_a.rt_addr = 6'd3;
    #1;
    chk32("r9_read", bus_a.rs, 32'd55);
    reset = 1'b1;
    tick();
    #1;
    chk1("run_rst_busy", bus_a.init_busy, 1'b1);
    chk32("run_rst_rs", bus_a.rs, 32'h0);
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) tick();
    reset = 1'b1;
    tick();
    #1;
    chk1("mid_rst_busy", bus_a.init_busy, 1'b1);
    reset = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      #1;
      if (k == 63) chk1("reclr_busy_63", bus_a.init_busy, 1'b1);
      if (k == 64) chk1("reclr_busy_64", bus_a.init_busy, 1'b0);
    end
    #1;
    chk32("r9_rezeroed", bus_a.rs, 32'h0);
    chk32("r3_rezeroed", bus_a.rt, 32'h0);
    chk32("d40_r39_rezeroed", bus_b.rs, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
